// File: rtl/contador_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : contador_arbiter
//  Description : Round-robin scheduler sharing one enable-driven counter
//                between N_REQ requesters. A winner gets a burst of len
//                enables, then a one-cycle done pulse reports whether the
//                burst was aborted and whether the counter result matched.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*LEN_W-1:0] len_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   cnt_en_o,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   aborted_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] win_q,    win_d;
    logic [IDX_W-1:0] ptr_q,    ptr_d;
    logic [LEN_W-1:0] rem_q,    rem_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [WIDTH-1:0] start_q,  start_d;
    logic             abort_q,  abort_d;

    logic [LEN_W-1:0] w_len [N_REQ];
    logic [N_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic             w_win_req;
    logic [WIDTH-1:0] w_expect;

    // Unpack the flat length bus and build the one-hot form of the latched winner
    genvar k;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_req
            assign w_len[k]    = len_i[k*LEN_W +: LEN_W];
            assign w_win_oh[k] = (win_q == IDX_W'(k));
        end
    endgenerate

    assign w_win_req = req_i[win_q];
    // Expected counter value; wrap-around of the counter is legal
    assign w_expect  = start_q + WIDTH'(issued_q);

    // Round-robin search: first active request starting at ptr, wrapping
    always_comb begin
        logic [IDX_W:0] w_sum;
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            if (!w_any && req_i[w_sum[IDX_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[IDX_W-1:0];
            end
        end
    end

    // Next-state logic for the IDLE -> BURST -> DONE sequence
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        issued_d = issued_q;
        start_d  = start_q;
        abort_d  = abort_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    win_d    = w_pick;
                    rem_d    = w_len[w_pick];
                    start_d  = data_i;
                    issued_d = '0;
                    abort_d  = 1'b0;
                    state_d  = (w_len[w_pick] == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (!w_win_req) begin
                    // Requester gave up: no enable this cycle, report abort
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d    = rem_q - 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ptr_d   = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; the counter itself is untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            ptr_q    <= '0;
            rem_q    <= '0;
            issued_q <= '0;
            start_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            issued_q <= issued_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign gnt_o     = (state_q == S_BURST) ? w_win_oh : '0;
    assign cnt_en_o  = (state_q == S_BURST) && w_win_req;
    assign done_o    = (state_q == S_DONE) ? w_win_oh : '0;
    assign aborted_o = (state_q == S_DONE) && abort_q;
    assign err_o     = (state_q == S_DONE) && (data_i != w_expect);

endmodule
`default_nettype wire
